// File: rtl/button_reader.sv
// button_reader: synchronises and debounces raw push-buttons, reports debounced
// levels, one-cycle press/release pulses and a queued event stream.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_btn[N_BTN]         raw button pins (asynchronous, active-high)
//   o_btn[N_BTN]         debounced level
//   o_press/o_release    one-cycle pulse on accepted 0->1 / 1->0
//   o_evt_valid          event queue not empty
//   o_evt_code           {type(1=press), button index} of queue head
//   i_evt_ready          consumer pops the head when valid & ready
//   o_ovf                sticky: pending event overwritten before queueing
//   i_ovf_clr            synchronous clear of o_ovf
module button_reader #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH      = 4,
  localparam int unsigned IDX_W          = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic             o_evt_valid,
  output logic [IDX_W:0]   o_evt_code,
  input  logic             i_evt_ready,
  output logic             o_ovf,
  input  logic             i_ovf_clr
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CODE_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(FIFO_DEPTH);

  logic [N_BTN-1:0] sync1, sync2;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] btn_d, rise_d, fall_d, acc;

  logic [N_BTN-1:0] pend_q, ptype_q, pend_d, ptype_d, grant, clr_mask;
  logic             found, free, push, pop, ovf_set;
  logic [IDX_W-1:0] grant_idx;
  logic [CODE_W-1:0] push_code;

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_q, wr_q, rd_d, wr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [CODE_W-1:0] head_d;

  // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_d[i]  = '0;
      btn_d[i]  = o_btn[i];
      rise_d[i] = 1'b0;
      fall_d[i] = 1'b0;
      if (sync2[i] != o_btn[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          btn_d[i]  = sync2[i];
          rise_d[i] = sync2[i];
          fall_d[i] = ~sync2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    acc = rise_d | fall_d;
  end

  // Arbiter: lowest-index pending button goes to the queue when a slot is free.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (pend_q[i] && !found) begin
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        found     = 1'b1;
      end
    end
    pop       = o_evt_valid & i_evt_ready;
    free      = (count_q != FULL) || pop;
    push      = found && free;
    push_code = {ptype_q[grant_idx], grant_idx};
    clr_mask  = push ? grant : '0;
    // A new transition beats a same-cycle dequeue; only an unqueued event counts as lost.
    pend_d    = (pend_q & ~clr_mask) | acc;
    ovf_set   = |(acc & pend_q & ~clr_mask);
    for (int i = 0; i < int'(N_BTN); i++) begin
      ptype_d[i] = acc[i] ? btn_d[i] : ptype_q[i];
    end
  end

  // FIFO pointer/count update and registered head lookahead.
  always_comb begin
    rd_d = pop  ? rd_q + PTR_W'(1) : rd_q;
    wr_d = push ? wr_q + PTR_W'(1) : wr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0) begin
      head_d = '0;
    end else if (push && (rd_d == wr_q)) begin
      // Head slot is the one being written this cycle.
      head_d = push_code;
    end else begin
      head_d = mem[rd_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      o_btn       <= '0;
      o_press     <= '0;
      o_release   <= '0;
      pend_q      <= '0;
      ptype_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      o_evt_valid <= 1'b0;
      o_evt_code  <= '0;
      o_ovf       <= 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      sync1       <= i_btn;
      sync2       <= sync1;
      o_btn       <= btn_d;
      o_press     <= rise_d;
      o_release   <= fall_d;
      pend_q      <= pend_d;
      ptype_q     <= ptype_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      o_evt_valid <= (count_d != '0);
      o_evt_code  <= head_d;
      o_ovf       <= ovf_set ? 1'b1 : (i_ovf_clr ? 1'b0 : o_ovf);
      for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= cnt_d[i];
      if (push) mem[wr_q] <= push_code;
    end
  end

endmodule
